// File: rtl/noc_credit_rx_endpoint.sv
// Receive endpoint of a valid/yummy credit link: DEPTH-entry show-ahead FIFO, one yummy per drained flit.
// Optional NOC_RX_BYPASS_EN: zero-latency pass-through of a flit arriving at an empty FIFO.
module noc_credit_rx_endpoint #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              yummy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [31:0]       rx_flits_o,
    output logic              overflow_o
);

    localparam int               PTR_W    = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_nxt_s;
    logic              yummy_r;
    logic              overflow_r;
    logic [31:0]       rx_flits_r;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              bypass_s;
    logic              drop_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == FULL_CNT);

    // Transfer decode: pop, push, bypass consumption and overflow drop
    always_comb begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        bypass_s = 1'b0;
        drop_s   = 1'b0;
`ifdef NOC_RX_BYPASS_EN
        bypass_s = empty_s && valid_i && ready_i;
`endif
        if (!empty_s && ready_i) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        // A full FIFO still accepts a flit when the head leaves in the same cycle
        if (valid_i && !bypass_s && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        drop_s = valid_i && full_s && !pop_s;
    end

    // Next occupancy and next registered head value
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        // data_o is registered, so the head after this edge is chosen one cycle early
        if (pop_s) begin
            if (count_r == CNT_ONE) begin
                if (push_s) begin
                    head_nxt_s = data_i;
                end else begin
                    head_nxt_s = head_r;
                end
            end else begin
                head_nxt_s = mem_r[rd_ptr_r + PTR_ONE];
            end
        end else if (empty_s && valid_i) begin
            head_nxt_s = data_i;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers, occupancy, head, credit return and statistics
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            head_r     <= {DATA_W{1'b0}};
            yummy_r    <= 1'b0;
            overflow_r <= 1'b0;
            rx_flits_r <= 32'd0;
        end else begin
            count_r    <= count_nxt_s;
            head_r     <= head_nxt_s;
            yummy_r    <= pop_s || bypass_s;
            overflow_r <= overflow_r || drop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s || bypass_s) begin
                rx_flits_r <= rx_flits_r + 32'd1;
            end
        end
    end

`ifdef NOC_RX_BYPASS_EN
    assign valid_o = !empty_s || valid_i;
    assign data_o  = (empty_s && valid_i) ? data_i : head_r;
`else
    assign valid_o = !empty_s;
    assign data_o  = head_r;
`endif
    assign yummy_o    = yummy_r;
    assign count_o    = count_r;
    assign rx_flits_o = rx_flits_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_noc_credit_rx_endpoint.sv
// Self-checking bench for noc_credit_rx_endpoint against a queue-based reference model.
module tb_noc_credit_rx_endpoint;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef NOC_RX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn_i;
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              yummy_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
    logic [CNT_W-1:0]  count_o;
    logic [31:0]       rx_flits_o;
    logic              overflow_o;

    noc_credit_rx_endpoint #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .data_i(data_i),
        .yummy_o(yummy_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .count_o(count_o), .rx_flits_o(rx_flits_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    bit                exp_yummy;
    bit                exp_ovf;
    logic [31:0]       exp_rx;
    int                yummy_seen;
    bit                last_yummy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_yummy = 1'b0;
        exp_ovf   = 1'b0;
        exp_rx    = 32'd0;
    endtask

    // One clock cycle: apply inputs, compare outputs with the model, advance the model
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        bit                ev;
        bit                byp;
        logic [DATA_W-1:0] ed;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        byp = BYP && (q.size() == 0) && v;
        ev  = (q.size() != 0) || byp;
        ed  = (q.size() != 0) ? q[0] : d;
        check_eq("valid_o", 64'(valid_o), 64'(ev));
        if (ev) check_eq("data_o", data_o, ed);
        check_eq("count_o", 64'(count_o), 64'(q.size()));
        check_eq("yummy_o", 64'(yummy_o), 64'(exp_yummy));
        check_eq("overflow_o", 64'(overflow_o), 64'(exp_ovf));
        check_eq("rx_flits_o", 64'(rx_flits_o), 64'(exp_rx));
        last_yummy = yummy_o;
        if (yummy_o) yummy_seen++;
        exp_yummy = ev && r;
        if (byp && r) begin
            exp_rx++;
        end else begin
            if (ev && r) void'(q.pop_front());
            if (v) begin
                if (q.size() < DEPTH) begin
                    q.push_back(d);
                    exp_rx++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        rstn_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(valid_o), 64'd0);
        check_eq({tag, "_data"}, data_o, 64'd0);
        check_eq({tag, "_yummy"}, 64'(yummy_o), 64'd0);
        check_eq({tag, "_count"}, 64'(count_o), 64'd0);
        check_eq({tag, "_rx"}, 64'(rx_flits_o), 64'd0);
        check_eq({tag, "_ovf"}, 64'(overflow_o), 64'd0);
    endtask

    task automatic single_flit();
        step(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        repeat (3) step(1'b0, 64'd0, 1'b1);
        check_eq("single_rx", 64'(rx_flits_o), 64'd1);
    endtask

    initial begin
        int credits;
        int sent;
        int ys0;
        int cyc;
        yummy_seen = 0;
        do_reset();
        check_zero_outputs("reset");

        // Single flit through an empty FIFO
        single_flit();

        // Fill then drain four flits
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1);
        step(1'b0, 64'd0, 1'b0);

        // Overflow on a full FIFO with no pop
        for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b0);
        step(1'b1, 64'd5, 1'b0);
        step(1'b0, 64'd0, 1'b0);
        check_eq("ovf_sticky", 64'(overflow_o), 64'd1);
        check_eq("ovf_rx", 64'(rx_flits_o), 64'd8);
        for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b0);
        step(1'b1, 64'd5, 1'b1);
        check_eq("full_pp_count", 64'(count_o), 64'd4);
        check_eq("full_pp_ovf", 64'(overflow_o), 64'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 1'b1);

        // Streaming 20 flits under credit flow control, ready toggling
        do_reset();
        credits = DEPTH;
        sent = 0;
        ys0 = yummy_seen;
        cyc = 0;
        while ((sent < 20 || (yummy_seen - ys0) < 20) && cyc < 400) begin
            if (sent < 20 && credits > 0 && $urandom_range(0, 3) != 0) begin
                credits--;
                sent++;
                step(1'b1, 64'(100 + sent), (cyc % 2) == 0);
            end else begin
                step(1'b0, 64'd0, (cyc % 2) == 0);
            end
            if (last_yummy) credits++;
            cyc++;
        end
        check_eq("stream_budget", 64'(cyc < 400), 64'd1);
        check_eq("stream_yummies", 64'(yummy_seen - ys0), 64'd20);
        check_eq("stream_ovf", 64'(overflow_o), 64'd0);
        check_eq("stream_rx", 64'(rx_flits_o), 64'd20);

        // Reset asserted mid-stream with a pop in progress
        do_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, 64'(i), 1'b0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        #2;
        rstn_i = 1'b0;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        step(1'b0, 64'd0, 1'b0);
        single_flit();

        // Unconstrained random traffic, including overflow cases
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
